utf8_stream_decoder: RTL and testbench

UTF8_STREAM_DECODER -- requirements
Module: utf8_stream_decoder

---
 rtl/utf8_stream_decoder_if.sv | 20 ++
 rtl/utf8_stream_decoder.sv | 129 ++++++++++++
 tb/tb_utf8_stream_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/utf8_stream_decoder_if.sv
// utf8_stream_decoder_if: byte-in / code-point-out stream handshake bundle
interface utf8_stream_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_byte;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_code_point;
    logic        out_error;
    logic        out_last;
    modport master (
        output in_valid, in_byte, in_last, out_ready,
        input  in_ready, out_valid, out_code_point, out_error, out_last
    );
    modport slave (
        input  in_valid, in_byte, in_last, out_ready,
        output in_ready, out_valid, out_code_point, out_error, out_last
    );
endinterface

// File: rtl/utf8_stream_decoder.sv
// utf8_stream_decoder: streaming UTF-8 to code point decoder with error handling and output FIFO
module utf8_stream_decoder #(
    parameter int ERR_MODE  = 1,
    parameter int OUT_DEPTH = 4,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    utf8_stream_decoder_if.slave s,
    output logic                 halted,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int CW = AW + 1;
    localparam bit SUB = (ERR_MODE != 0);
    typedef enum logic [1:0] {IDLE, NEED1, NEED2, NEED3} state_t;
    state_t        state, state_n;
    logic [20:0]   acc, acc_n, acc_sh, cp;
    logic [7:0]    lo, hi, lo_n, hi_n, b, rp_byte;
    logic          reproc, reproc_n, rp_last, b_last;
    logic          space, fire, pop, push, err, retry, cp_last, wr_en;
    logic [22:0]   wr_data;
    logic [22:0]   mem [OUT_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    assign space      = count != CW'(OUT_DEPTH);
    assign s.in_ready = space && !halted && !reproc;
    assign fire       = reproc ? space && !halted : s.in_valid && s.in_ready;
    assign b          = reproc ? rp_byte : s.in_byte;
    assign b_last     = reproc ? rp_last : s.in_last;
    assign acc_sh     = {acc[14:0], b[5:0]};
    assign pop        = s.out_valid && s.out_ready;
    assign busy       = state != IDLE;
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        lo_n     = lo;
        hi_n     = hi;
        reproc_n = reproc;
        push     = 1'b0;
        err      = 1'b0;
        retry    = 1'b0;
        cp       = acc_sh;
        cp_last  = b_last;
        if (fire) begin
            reproc_n = 1'b0;
            if (state == IDLE) begin
                if (!b[7]) begin
                    push = 1'b1;
                    cp   = {13'd0, b};
                end else if (b >= 8'hC2 && b <= 8'hDF) begin
                    state_n = NEED1;
                    acc_n   = {16'd0, b[4:0]};
                    lo_n    = 8'h80;
                    hi_n    = 8'hBF;
                end else if (b[7:4] == 4'hE) begin
                    state_n = NEED2;
                    acc_n   = {17'd0, b[3:0]};
                    lo_n    = b == 8'hE0 ? 8'hA0 : 8'h80;
                    hi_n    = b == 8'hED ? 8'h9F : 8'hBF;
                end else if (b >= 8'hF0 && b <= 8'hF4) begin
                    state_n = NEED3;
                    acc_n   = {18'd0, b[2:0]};
                    lo_n    = b == 8'hF0 ? 8'h90 : 8'h80;
                    hi_n    = b == 8'hF4 ? 8'h8F : 8'hBF;
                end else begin
                    err = 1'b1;
                end
            end else if (b >= lo && b <= hi) begin
                acc_n   = acc_sh;
                lo_n    = 8'h80;
                hi_n    = 8'hBF;
                push    = state == NEED1;
                state_n = state == NEED3 ? NEED2 : state == NEED2 ? NEED1 : IDLE;
            end else begin
                // the offending byte is held back and replayed as a lead byte next cycle
                err      = 1'b1;
                retry    = 1'b1;
                state_n  = IDLE;
                reproc_n = SUB;
            end
            if (!retry && b_last && state_n != IDLE) begin
                err     = 1'b1;
                state_n = IDLE;
            end
        end
        wr_en   = push || (err && SUB);
        wr_data = err ? {1'b1, b_last && !retry, 21'h00FFFD} : {1'b0, cp_last, cp};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            lo        <= '0;
            hi        <= '0;
            reproc    <= 1'b0;
            rp_byte   <= '0;
            rp_last   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            halted    <= 1'b0;
            err_count <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            lo     <= lo_n;
            hi     <= hi_n;
            reproc <= reproc_n;
            if (fire) begin
                rp_byte <= b;
                rp_last <= b_last;
            end
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(pop);
            if (err) begin
                halted    <= halted || !SUB;
                err_count <= &err_count ? err_count : err_count + ERR_CNT_W'(1);
            end
        end
    end
    always_ff @(posedge clock) if (wr_en) mem[wr_ptr] <= wr_data;
    assign s.out_valid      = count != '0;
    assign s.out_code_point = s.out_valid ? mem[rd_ptr][20:0] : '0;
    assign s.out_last       = s.out_valid && mem[rd_ptr][21];
    assign s.out_error      = s.out_valid && mem[rd_ptr][22];
endmodule

// File: tb/tb_utf8_stream_decoder.sv
// tb_utf8_stream_decoder: directed stimulus with queued expectations checked by output monitors
module tb_utf8_stream_decoder;
    logic clock = 0;
    logic reset = 1;
    logic [2:0] iv = '0, il = '0, ordy = '1;
    logic [7:0] ib [3];
    wire  [2:0] ir;
    logic h1, h0, h2, b1, b0, b2;
    logic [15:0] e1, e0;
    logic [1:0]  e2;
    int chk = 0, err = 0;
    logic [22:0] q1 [$];
    logic [22:0] q0 [$];
    localparam logic [22:0] FE = 23'h40FFFD, FEL = 23'h60FFFD;
    utf8_stream_decoder_if a();
    utf8_stream_decoder_if b();
    utf8_stream_decoder_if c();
    assign a.in_valid = iv[0];
    assign b.in_valid = iv[1];
    assign c.in_valid = iv[2];
    assign a.in_last = il[0];
    assign b.in_last = il[1];
    assign c.in_last = il[2];
    assign a.in_byte = ib[0];
    assign b.in_byte = ib[1];
    assign c.in_byte = ib[2];
    assign a.out_ready = ordy[0];
    assign b.out_ready = ordy[1];
    assign c.out_ready = ordy[2];
    assign ir = {c.in_ready, b.in_ready, a.in_ready};
    utf8_stream_decoder #(.ERR_MODE(1)) u1 (.clock(clock), .reset(reset), .s(a), .halted(h1), .busy(b1), .err_count(e1));
    utf8_stream_decoder #(.ERR_MODE(0)) u0 (.clock(clock), .reset(reset), .s(b), .halted(h0), .busy(b0), .err_count(e0));
    utf8_stream_decoder #(.ERR_MODE(1), .ERR_CNT_W(2)) u2 (.clock(clock), .reset(reset), .s(c), .halted(h2), .busy(b2), .err_count(e2));
    always #5 clock = ~clock;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clock) if (a.out_valid && a.out_ready) begin
        if (q1.size() == 0) begin
            chk++; err++;
            $display("FAIL mon1 unexpected: got %h expected none", {a.out_error, a.out_last, a.out_code_point});
        end else check("mon1", {9'd0, a.out_error, a.out_last, a.out_code_point}, {9'd0, q1.pop_front()});
    end
    always @(negedge clock) if (b.out_valid && b.out_ready) begin
        if (q0.size() == 0) begin
            chk++; err++;
            $display("FAIL mon0 unexpected: got %h expected none", {b.out_error, b.out_last, b.out_code_point});
        end else check("mon0", {9'd0, b.out_error, b.out_last, b.out_code_point}, {9'd0, q0.pop_front()});
    end
    function automatic void ex(input int d, input logic [22:0] v);
        if (d == 0) q1.push_back(v);
        else q0.push_back(v);
    endfunction
    task automatic send(input int d, input logic [7:0] by, input logic lst);
        int n = 0;
        iv[d] = 1'b1;
        ib[d] = by;
        il[d] = lst;
        while (!ir[d] && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        if (n == 200) begin
            chk++; err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 (dut %0d byte %h)", d, by);
        end
        @(posedge clock); #1;
        iv[d] = 1'b0;
    endtask
    task automatic seq(input logic [31:0] v, input int n, input logic lst);
        for (int i = n - 1; i >= 0; i--) send(0, v[8*i +: 8], lst && i == 0);
    endtask
    task automatic wait_drain;
        int n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
            @(posedge clock);
            n++;
        end
        #1;
        if (n == 200) begin
            chk++; err++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q1.size(), q0.size());
        end
    endtask
    task automatic do_reset;
        reset = 1'b1;
        @(posedge clock); #1;
        check("rst_out", {a.out_valid, a.out_error, a.out_last, b1, h1, a.out_code_point}, 0);
        check("rst_err", e1, 0);
        reset = 1'b0;
        check("rst_ready", ir, 3'b111);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        ib[0] = 0; ib[1] = 0; ib[2] = 0;
        do_reset;
        ex(0, 23'h000041); ex(0, 23'h0000E9); ex(0, 23'h0020AC); ex(0, 23'h21F600);
        send(0, 8'h41, 0);
        check("latency", a.out_valid, 1);
        send(0, 8'hC3, 0);
        check("busy_mid", b1, 1);
        send(0, 8'hA9, 0);
        seq(32'hE282AC, 3, 0);
        seq(32'hF09F9880, 4, 1);
        wait_drain;
        check("err_clean", e1, 0);
        check("busy_idle", b1, 0);
        ex(0, 23'h000080); ex(0, 23'h00D7FF); ex(0, 23'h00FFFF); ex(0, 23'h010000); ex(0, 23'h30FFFF);
        seq(32'hC280, 2, 0);
        seq(32'hED9FBF, 3, 0);
        seq(32'hEFBFBF, 3, 0);
        seq(32'hF0908080, 4, 0);
        seq(32'hF48FBFBF, 4, 1);
        wait_drain;
        ex(0, FE); ex(0, 23'h000041);
        seq(32'hE041, 2, 0);
        check("reproc_stall", ir[0], 0);
        @(posedge clock); #1;
        check("reproc_resume", ir[0], 1);
        wait_drain;
        check("err_e041", e1, 1);
        ex(0, FE); ex(0, FE);
        seq(32'hE080, 2, 0);
        wait_drain;
        check("err_e080", e1, 3);
        ex(0, FE); ex(0, 23'h200041);
        seq(32'hE041, 2, 1);
        ex(0, FEL);
        seq(32'hE282, 2, 1);
        ex(0, FEL);
        send(0, 8'hFF, 1);
        wait_drain;
        check("err_last", e1, 6);
        do_reset;
        ex(0, FE); ex(0, FE); ex(0, FE); ex(0, FE);
        seq(32'hEDA0, 2, 0);
        seq(32'hF490, 2, 0);
        wait_drain;
        check("err_surrogate", e1, 4);
        seq(32'hE282, 2, 0);
        check("busy_pre_rst", b1, 1);
        do_reset;
        repeat (3) @(posedge clock);
        #1;
        check("no_fffd_rst", a.out_valid, 0);
        ex(0, 23'h000041);
        send(0, 8'h41, 0);
        wait_drain;
        check("err_after_rst", e1, 0);
        ordy[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ex(0, 23'(8'h61 + i));
            send(0, 8'(8'h61 + i), 0);
        end
        check("full_ready", ir[0], 0);
        check("full_valid", a.out_valid, 1);
        ordy[0] = 1'b1;
        check("no_passthru", ir[0], 0);
        ex(0, 23'h000065); ex(0, 23'h000066);
        send(0, 8'h65, 0);
        send(0, 8'h66, 0);
        wait_drain;
        send(1, 8'hC0, 0);
        check("halt_set", h0, 1);
        check("halt_ready", ir[1], 0);
        check("halt_err", e0, 1);
        repeat (3) @(posedge clock);
        #1;
        check("halt_hold", {ir[1], b.out_valid, b0, h0}, 4'b0001);
        do_reset;
        check("halt_clr", h0, 0);
        ex(1, 23'h000041);
        send(1, 8'h41, 0);
        wait_drain;
        repeat (5) send(2, 8'hFF, 0);
        check("err_sat", e2, 3);
        check("sat_flags", {h2, b2}, 0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
